i2c_regctl: RTL and testbench

Register-file controller that sits behind the I2C slave byte interface and sequences it as a standard pointer-addressed register map. The first written byte after an address match sets a register pointer. Following written bytes store into the addressed registers with auto-increment. Reads stream registers from the pointer onward. A local host port gives on-chip logic concurrent access to the same registers, with fixed arbitration.

---
 rtl/i2c_regctl_pkg.sv | 16 +
 rtl/i2c_regfile.sv | 61 ++++++
 rtl/i2c_regctl.sv | 144 ++++++++++++++
 tb/tb_i2c_regctl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_regctl_pkg.sv
// Shared definitions for the I2C register-map controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_regctl_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] DEF_RESET_VALUE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PTR   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_e;

endpackage

// File: rtl/i2c_regfile.sv
// Register array with an I2C write port (priority) and a host write port, plus RO mask.
// Latency: writes land next edge; rd_data_o combinational; host_rdata_o 1 cycle, write-through.
// Backpressure: none; a host write losing to an I2C write on the same address is dropped.
module i2c_regfile
    import i2c_regctl_pkg::*;
#(
    parameter int                     ADDR_W      = 4,
    parameter logic [BYTE_W-1:0]      RESET_VALUE = DEF_RESET_VALUE,
    parameter logic [(2**ADDR_W)-1:0] RO_MASK     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i2c_we_i,
    input  logic [ADDR_W-1:0] i2c_addr_i,
    input  logic [BYTE_W-1:0] i2c_wdata_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [BYTE_W-1:0] host_wdata_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic [BYTE_W-1:0] host_rdata_o,
    output logic              i2c_commit_o,
    output logic              host_collide_o
);

    localparam int REG_COUNT = 2**ADDR_W;

    logic [BYTE_W-1:0] regs_q [REG_COUNT];
    logic [BYTE_W-1:0] regs_d [REG_COUNT];
    logic [BYTE_W-1:0] host_rdata_q;

    // Resolve both write ports into the next array image; I2C overrides host on a shared address.
    always_comb begin
        regs_d         = regs_q;
        i2c_commit_o   = i2c_we_i && !RO_MASK[i2c_addr_i];
        host_collide_o = host_we_i && i2c_commit_o && (host_addr_i == i2c_addr_i);
        if (host_we_i && !host_collide_o) begin
            regs_d[host_addr_i] = host_wdata_i;
        end
        if (i2c_commit_o) begin
            regs_d[i2c_addr_i] = i2c_wdata_i;
        end
    end

    // Array state and the host read port, which samples the post-write image.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
            host_rdata_q <= RESET_VALUE;
        end else begin
            regs_q       <= regs_d;
            host_rdata_q <= regs_d[host_addr_i];
        end
    end

    assign rd_data_o    = regs_q[rd_addr_i];
    assign host_rdata_o = host_rdata_q;

endmodule

// File: rtl/i2c_regctl.sv
// Pointer-addressed register map behind an I2C slave byte interface, with a local host port.
// Latency: rx byte -> register/wr_strobe in 1 cycle; read start or tx_taken -> tx_data in 1 cycle.
// Backpressure: none; the slave paces reads with tx_taken, stray bytes are dropped and flagged.
module i2c_regctl
    import i2c_regctl_pkg::*;
#(
    parameter int                     ADDR_W      = 4,
    parameter logic [BYTE_W-1:0]      RESET_VALUE = DEF_RESET_VALUE,
    parameter logic [(2**ADDR_W)-1:0] RO_MASK     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              txn_start,
    input  logic              txn_rw,
    input  logic              txn_stop,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_taken,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_we,
    input  logic [BYTE_W-1:0] host_wdata,
    output logic [BYTE_W-1:0] host_rdata,
    output logic              host_collide,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rx_ignored,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              wr_strobe_q, host_collide_q, rx_ignored_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic              i2c_we, load_tx, rx_ign;
    logic [BYTE_W-1:0] rf_rd_data;
    logic              rf_commit, rf_collide;

    // Pointer bits above ADDR_W are intentionally discarded.
    logic              rx_data_unused;
    assign rx_data_unused = ^rx_data;

    i2c_regfile #(
        .ADDR_W      (ADDR_W),
        .RESET_VALUE (RESET_VALUE),
        .RO_MASK     (RO_MASK)
    ) u_regfile (
        .clk            (clk),
        .reset          (reset),
        .i2c_we_i       (i2c_we),
        .i2c_addr_i     (ptr_q),
        .i2c_wdata_i    (rx_data),
        .host_we_i      (host_we),
        .host_addr_i    (host_addr),
        .host_wdata_i   (host_wdata),
        .rd_addr_i      (ptr_d),
        .rd_data_o      (rf_rd_data),
        .host_rdata_o   (host_rdata),
        .i2c_commit_o   (rf_commit),
        .host_collide_o (rf_collide)
    );

    // Next state and pointer: a new START overrides everything, otherwise handle the byte event
    // for the current state, then let STOP return to IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        i2c_we  = 1'b0;
        load_tx = 1'b0;
        rx_ign  = 1'b0;
        if (txn_start) begin
            state_d = txn_rw ? ST_RDATA : ST_PTR;
            load_tx = txn_rw;
            rx_ign  = rx_valid;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rx_ign = rx_valid;
                end
                ST_PTR: begin
                    if (rx_valid) begin
                        ptr_d   = rx_data[ADDR_W-1:0];
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (rx_valid) begin
                        i2c_we = 1'b1;
                        ptr_d  = ptr_q + ADDR_W'(1);
                    end
                end
                ST_RDATA: begin
                    rx_ign = rx_valid;
                    if (tx_taken) begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        load_tx = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (txn_stop) begin
                state_d = ST_IDLE;
            end
        end
    end

    // The outgoing byte is a snapshot of the register the pointer lands on.
    always_comb begin
        tx_data_d = load_tx ? rf_rd_data : tx_data_q;
    end

    // Controller state and registered status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            tx_data_q      <= '0;
            wr_strobe_q    <= 1'b0;
            wr_addr_q      <= '0;
            host_collide_q <= 1'b0;
            rx_ignored_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            tx_data_q      <= tx_data_d;
            wr_strobe_q    <= rf_commit;
            if (rf_commit) begin
                wr_addr_q <= ptr_q;
            end
            host_collide_q <= rf_collide;
            rx_ignored_q   <= rx_ign;
        end
    end

    assign tx_data      = tx_data_q;
    assign wr_strobe    = wr_strobe_q;
    assign wr_addr      = wr_addr_q;
    assign host_collide = host_collide_q;
    assign rx_ignored   = rx_ignored_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_regctl.sv
// Bench for i2c_regctl: transaction-level driver with a register-map model feeding expectation queues.
// Latency: expectations are stamped with the cycle they must appear in.
// Backpressure: n/a.
module tb_i2c_regctl;

    localparam logic [15:0] RO = 16'h0004;

    logic       clk = 1'b0;
    logic       reset;
    logic       txn_start, txn_rw, txn_stop;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_taken;
    logic [3:0] host_addr;
    logic       host_we;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       host_collide, wr_strobe, rx_ignored, busy;
    logic [3:0] wr_addr;

    i2c_regctl #(.ADDR_W(4), .RESET_VALUE(8'h00), .RO_MASK(RO)) dut (
        .clk(clk), .reset(reset), .txn_start(txn_start), .txn_rw(txn_rw), .txn_stop(txn_stop),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_taken(tx_taken),
        .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_collide(host_collide), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .rx_ignored(rx_ignored), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [7:0] val; } exp_t;
    exp_t wr_q[$], col_q[$], ign_q[$], tx_q[$], hr_q[$];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: register contents, pointer, last byte offered.
    logic [7:0] mem [16];
    int         mptr;
    logic [7:0] mtx;

    function automatic exp_t mk(int c, logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        return e;
    endfunction

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, req);
        end
    endfunction

    // Monitor: compares DUT outputs against whatever the driver queued for this cycle.
    always @(negedge clk) begin
        bit e;
        e = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
        if (e || wr_strobe) begin
            chk("wr_strobe", {7'b0, wr_strobe}, {7'b0, e});
            if (e && wr_strobe) chk("wr_addr", {4'b0, wr_addr}, wr_q[0].val);
            if (e) void'(wr_q.pop_front());
        end
        e = (col_q.size() > 0) && (col_q[0].cyc == cyc);
        if (e || host_collide) begin
            chk("host_collide", {7'b0, host_collide}, {7'b0, e});
            if (e) void'(col_q.pop_front());
        end
        e = (ign_q.size() > 0) && (ign_q[0].cyc == cyc);
        if (e || rx_ignored) begin
            chk("rx_ignored", {7'b0, rx_ignored}, {7'b0, e});
            if (e) void'(ign_q.pop_front());
        end
        if ((tx_q.size() > 0) && (tx_q[0].cyc == cyc)) begin
            chk("tx_data", tx_data, tx_q[0].val);
            void'(tx_q.pop_front());
        end
        if ((hr_q.size() > 0) && (hr_q[0].cyc == cyc)) begin
            chk("host_rdata", host_rdata, hr_q[0].val);
            void'(hr_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        txn_start = 1'b0;
        txn_stop  = 1'b0;
        rx_valid  = 1'b0;
        tx_taken  = 1'b0;
        host_we   = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mptr = 0;
        mtx  = 8'h00;
    endtask

    task automatic start_w(input bit with_rx, input bit with_stop);
        txn_start = 1'b1;
        txn_rw    = 1'b0;
        txn_stop  = with_stop;
        if (with_rx) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom_range(0, 255));
            ign_q.push_back(mk(cyc + 1, 8'h00));
        end
        tick();
    endtask

    task automatic start_r();
        txn_start = 1'b1;
        txn_rw    = 1'b1;
        mtx       = mem[mptr];
        tx_q.push_back(mk(cyc + 1, mtx));
        tick();
    endtask

    task automatic stop();
        txn_stop = 1'b1;
        tick();
    endtask

    task automatic send_ptr(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        mptr     = b % 16;
        tick();
    endtask

    task automatic send_data(input logic [7:0] b, input bit hw, input int ha,
                             input logic [7:0] hd, input bit stp);
        bit i2c_ok;
        rx_valid = 1'b1;
        rx_data  = b;
        txn_stop = stp;
        i2c_ok   = !RO[mptr];
        if (i2c_ok) begin
            mem[mptr] = b;
            wr_q.push_back(mk(cyc + 1, 8'(mptr)));
        end
        if (hw) begin
            host_we    = 1'b1;
            host_addr  = 4'(ha);
            host_wdata = hd;
            if (i2c_ok && ha == mptr) col_q.push_back(mk(cyc + 1, 8'h00));
            else mem[ha] = hd;
            hr_q.push_back(mk(cyc + 1, mem[ha]));
        end
        mptr = (mptr + 1) % 16;
        tick();
    endtask

    task automatic taken();
        tx_taken = 1'b1;
        mptr     = (mptr + 1) % 16;
        mtx      = mem[mptr];
        tx_q.push_back(mk(cyc + 1, mtx));
        tick();
    endtask

    task automatic idle_taken();
        tx_taken = 1'b1;
        tx_q.push_back(mk(cyc + 1, mtx));
        tick();
    endtask

    task automatic host_wr(input int a, input logic [7:0] d);
        host_we    = 1'b1;
        host_addr  = 4'(a);
        host_wdata = d;
        mem[a]     = d;
        hr_q.push_back(mk(cyc + 1, d));
        tick();
    endtask

    task automatic host_rd(input int a);
        host_addr = 4'(a);
        hr_q.push_back(mk(cyc + 1, mem[a]));
        tick();
    endtask

    task automatic stray(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        ign_q.push_back(mk(cyc + 1, 8'h00));
        tick();
    endtask

    initial begin
        reset = 1'b1; txn_start = 1'b0; txn_rw = 1'b0; txn_stop = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; tx_taken = 1'b0;
        host_addr = 4'h0; host_we = 1'b0; host_wdata = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset tx_data", tx_data, 8'h00);
        chk("reset host_rdata", host_rdata, 8'h00);
        chk("reset busy", {7'b0, busy}, 8'h00);
        chk("reset wr_strobe", {7'b0, wr_strobe}, 8'h00);
        chk("reset host_collide", {7'b0, host_collide}, 8'h00);
        chk("reset rx_ignored", {7'b0, rx_ignored}, 8'h00);
        reset = 1'b0;

        // Pointer write then burst write.
        start_w(0, 0);
        chk("busy in write", {7'b0, busy}, 8'h01);
        send_ptr(8'h03);
        send_data(8'hA5, 0, 0, 8'h00, 0);
        send_data(8'h5A, 0, 0, 8'h00, 0);
        stop();
        chk("busy after stop", {7'b0, busy}, 8'h00);
        host_rd(3);
        host_rd(4);

        // Repeated-start read streams from the pointer.
        start_w(0, 0);
        send_ptr(8'h03);
        start_r();
        taken();
        taken();
        stop();

        // Wrap-around; reg1 preloaded so the final pointer is observable.
        host_wr(1, 8'hC3);
        start_w(0, 0);
        send_ptr(8'h0F);
        send_data(8'h11, 0, 0, 8'h00, 0);
        send_data(8'h22, 0, 0, 8'h00, 0);
        stop();
        host_rd(15);
        host_rd(0);
        start_r();
        stop();

        // Read-only register: I2C write dropped, pointer still advances, host can write.
        start_w(0, 0);
        send_ptr(8'h02);
        send_data(8'hFF, 0, 0, 8'h00, 0);
        stop();
        host_rd(2);
        start_r();
        stop();
        host_wr(2, 8'h77);

        // Same-address collision, then different-address concurrent writes.
        start_w(0, 0);
        send_ptr(8'h06);
        send_data(8'h10, 1, 6, 8'h20, 0);
        stop();
        start_w(0, 0);
        send_ptr(8'h06);
        send_data(8'h10, 1, 7, 8'h20, 0);
        stop();
        host_rd(6);

        // Snapshot: host write to the offered register leaves tx_data alone.
        start_w(0, 0);
        send_ptr(8'h04);
        start_r();
        tx_q.push_back(mk(cyc + 1, mtx));
        host_wr(4, 8'hEE);
        taken();
        stop();
        idle_taken();

        // Simultaneous events.
        start_w(0, 1);
        chk("start wins over stop", {7'b0, busy}, 8'h01);
        stop();
        start_w(1, 0);
        send_ptr(8'h89);
        send_data(8'h3C, 0, 0, 8'h00, 1);
        chk("busy after byte+stop", {7'b0, busy}, 8'h00);
        stray(8'h44);

        // Reset in the middle of a read.
        start_r();
        taken();
        reset = 1'b1;
        tick();
        model_reset();
        chk("tx_data after reset", tx_data, 8'h00);
        chk("busy after reset", {7'b0, busy}, 8'h00);
        host_wr(0, 8'h99);
        start_r();
        stop();

        // Randomized transactions.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    start_w(0, 0);
                    send_ptr(8'($urandom_range(0, 255)));
                    for (int k = $urandom_range(0, 4); k > 0; k--) begin
                        bit hw;
                        int ha;
                        hw = ($urandom_range(0, 2) == 0);
                        ha = ($urandom_range(0, 2) == 0) ? mptr : int'($urandom_range(0, 15));
                        send_data(8'($urandom_range(0, 255)), hw, ha, 8'($urandom_range(0, 255)), 0);
                    end
                    stop();
                end
                1: begin
                    start_r();
                    for (int k = $urandom_range(0, 4); k > 0; k--) taken();
                    stop();
                end
                2: begin
                    start_w(0, 0);
                    send_ptr(8'($urandom_range(0, 255)));
                    start_r();
                    for (int k = $urandom_range(0, 3); k > 0; k--) taken();
                    stop();
                end
                default: begin
                    host_wr(int'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                    host_rd(int'($urandom_range(0, 15)));
                    stray(8'($urandom_range(0, 255)));
                end
            endcase
        end

        repeat (3) tick();
        chk("expectation queues drained",
            8'(wr_q.size() + col_q.size() + ign_q.size() + tx_q.size() + hr_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
